free_list: RTL and testbench
============================

# free_list

Circular free list of physical register indices for the explicit-register-renaming core. It supplies a free physical register to rename/dispatch each cycle. It takes back the stale physical register that the retirement register file releases on every ROB commit with a nonzero architectural destination. On flush it rolls back all speculative allocations by restoring a retirement-head pointer, so no walk of the ROB is needed.

## Interface
Parameters:
- NUM_PHYS_REGS, default 64: physical register count; must be >32 and a power of two.
- PREG_W, default $clog2(NUM_PHYS_REGS): index width; equals PHYSICAL_REG_FILE_LENGTH.
- DEPTH, default NUM_PHYS_REGS-32: free list capacity.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset. Synchronous, active-high.
- alloc_req, input, 1: rename consumes one free register this cycle.
- alloc_preg, output, PREG_W: physical register at head. Valid only when alloc_valid=1.
- alloc_valid, output, 1: list non-empty.
- free_we, input, 1: ROB commit of an instruction with rd!=x0. Same strobe that writes the RRF.
- free_preg, input, PREG_W: stale mapping read out of the RRF for that commit.
- flush, input, 1: mispredict/exception recovery.
- count, output, $clog2(DEPTH)+1: number of free entries.

## Operation
- Storage: DEPTH entries, each PREG_W wide.
- Pointers: head (speculative read), retire_head (committed read) and tail (write). Each pointer is $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Empty when head==tail. Full when the low bits are equal and the wrap bits differ.
- count = tail - head, modulo 2·DEPTH.
- Allocate: alloc_req && alloc_valid && !flush → head+1.
  - alloc_req while empty is ignored: no pointer change, no error.
- Free: free_we → mem[tail] ← free_preg; tail+1; retire_head+1.
  - A commit makes the oldest speculative allocation permanent. Allocation and commit are both in program order, so one retire_head step per commit is exact.
- Flush: head ← retire_head after that cycle's commit update, i.e. retire_head + free_we.
  - alloc_req is ignored in the flush cycle.
  - free_we in the flush cycle is still fully applied.
- Simultaneous alloc and free:
  - Both take effect and count is unchanged.
  - No bypass. When empty, the freed register becomes visible the next cycle, and the alloc_req in that cycle is rejected.
- Overflow (free_we while full) is illegal by construction, since the register population is conserved. The bench asserts it never happens. The RTL drops the write and holds all pointers.
- free_preg==0 is never legal. Assert it.
- Pointer increments wrap modulo 2·DEPTH, toggling the wrap bit.

## Timing
- Reset values:
  - mem[i]=32+i
  - head=retire_head=0
  - tail={1'b1, 0}, i.e. the list starts full
  - count=DEPTH
  - alloc_valid=1
  - alloc_preg=32
- alloc_preg and alloc_valid are combinational from registered state: mem[head] and head!=tail. They do not depend on the current-cycle inputs.
- All state updates happen on posedge clk. A register freed in cycle N can be allocated in cycle N+1.
- Flush latency is one cycle: alloc_preg in cycle N+1 is mem[retire_head'].
- rst has priority over flush, which has priority over alloc. rst in mid-operation restores the full reset image in one cycle.

## Structure
- The params package holds NUM_PHYS_REGS, PHYSICAL_REG_FILE_LENGTH and FREE_LIST_DEPTH, shared with the RRF, RAT and ROB.
- A single module with no sub-modules. An internal pointer-increment function handles wrap.
- Assertions are bound in the bench:
  - no overflow
  - free_preg!=0
  - retire_head never passes head

## Test plan
- Reset, then alloc_req held for 33 cycles → alloc_preg 32,33,…,63 on cycles 1–32. alloc_valid=0 and count=0 on cycle 33; head stays put.
- Drain the list, then free_we with free_preg=5 → the next cycle shows alloc_valid=1, alloc_preg=5, count=1.
- From reset: allocate 32, 33, 34; commit once (free_we, free_preg=7); flush → the next cycle shows alloc_preg=33 and count=DEPTH-1+1=32. Register 7 sits at the tail.
- count=1, alloc_req and free_we(9) in the same cycle → count stays 1 and the next alloc_preg is 9. With count=0 in the same situation → the alloc is rejected, and the next cycle shows count=1, alloc_preg=9.
- flush and free_we(12) in the same cycle after 4 allocations → head = old retire_head+1, tail advanced, and 12 is allocatable after the remaining entries.
- Assert rst mid-drain after 10 allocations → the next cycle shows alloc_preg=32 and count=32.

Source files
------------

// File: rtl/free_list_pkg.sv
// free_list_pkg: register-file sizing shared by the free list, RRF, RAT and ROB.
package free_list_pkg;
    localparam int NUM_PHYS_REGS = 64;
    localparam int PHYSICAL_REG_FILE_LENGTH = $clog2(NUM_PHYS_REGS);
    localparam int FREE_LIST_DEPTH = NUM_PHYS_REGS - 32;
endpackage

// File: rtl/free_list.sv
// free_list: circular free list of physical register indices with flush rollback to the retirement head.
module free_list #(
    parameter int NUM_PHYS_REGS = free_list_pkg::NUM_PHYS_REGS,
    parameter int PREG_W = $clog2(NUM_PHYS_REGS),
    parameter int DEPTH = NUM_PHYS_REGS - 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_req,
    output logic [PREG_W-1:0]        alloc_preg,
    output logic                     alloc_valid,
    input  logic                     free_we,
    input  logic [PREG_W-1:0]        free_preg,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    logic [PREG_W-1:0] mem [DEPTH];
    logic [AW:0] head, retire_head, tail, rh_next;
    logic full, free_ok, alloc_ok;
    // Low bits wrap at DEPTH-1 so non-power-of-two depths still toggle the wrap bit correctly.
    function automatic logic [AW:0] inc(input logic [AW:0] p);
        return (p[AW-1:0] == AW'(DEPTH-1)) ? {~p[AW], AW'(0)} : p + ONE;
    endfunction
    assign alloc_valid = head != tail;
    assign alloc_preg = mem[head[AW-1:0]];
    assign full = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign count = {1'b0, tail[AW-1:0]} - {1'b0, head[AW-1:0]} + ((head[AW] != tail[AW]) ? DEPTH_W : '0);
    assign alloc_ok = alloc_req && alloc_valid && !flush;
    assign free_ok = free_we && !full;
    assign rh_next = free_ok ? inc(retire_head) : retire_head;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= PREG_W'(32 + i);
            head <= '0;
            retire_head <= '0;
            tail <= {1'b1, AW'(0)};
        end else begin
            if (free_ok) mem[tail[AW-1:0]] <= free_preg;
            tail <= free_ok ? inc(tail) : tail;
            retire_head <= rh_next;
            head <= flush ? rh_next : alloc_ok ? inc(head) : head;
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: scoreboard bench for free_list against a queue model of committed and speculative entries.
module tb_free_list;
    import free_list_pkg::*;
    localparam int D = FREE_LIST_DEPTH;
    localparam int W = PHYSICAL_REG_FILE_LENGTH;
    logic clk, rst, alloc_req, alloc_valid, free_we, flush;
    logic [W-1:0] alloc_preg, free_preg;
    logic [$clog2(D):0] count;
    free_list dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_preg(alloc_preg),
        .alloc_valid(alloc_valid), .free_we(free_we), .free_preg(free_preg),
        .flush(flush), .count(count)
    );
    typedef struct { int v; int c; int p; } exp_t;
    exp_t sb[$];
    int fl[$];
    int spec_n;
    int checks = 0;
    int failures = 0;
    string ph = "reset";
    bit started = 0;
    logic [W-1:0] gap;
    initial clk = 0;
    always #5 clk = ~clk;
    assign gap = dut.head - dut.retire_head;
    always @(negedge clk) begin
        if (started && !rst) begin
            assert (!(free_we && count == D)) else $error("FAIL assert_overflow count=%0d", count);
            assert (!free_we || free_preg != 0) else $error("FAIL assert_preg0 free_preg=%0d", free_preg);
            assert (gap <= D) else $error("FAIL assert_retire gap=%0d", gap);
        end
    end
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s/%s got=%0d exp=%0d", ph, tag, got, exp);
        end
    endtask
    // Model: fl holds entries from retire_head to tail; the first spec_n are speculatively allocated.
    task automatic cyc(input bit r, input bit q, input bit w, input int p, input bit f);
        exp_t e;
        rst = r; alloc_req = q; free_we = w; free_preg = W'(p); flush = f;
        if (r) begin
            fl.delete();
            for (int i = 0; i < D; i++) fl.push_back(32 + i);
            spec_n = 0;
        end else begin
            if (q && !f && spec_n < fl.size()) spec_n++;
            if (w) begin
                void'(fl.pop_front());
                fl.push_back(p);
                spec_n--;
            end
            if (f) spec_n = 0;
        end
        e.v = spec_n < fl.size() ? 1 : 0;
        e.c = fl.size() - spec_n;
        e.p = e.v ? fl[spec_n] : 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        started = 1;
        e = sb.pop_front();
        chk("valid", int'(alloc_valid), e.v);
        chk("count", int'(count), e.c);
        if (e.v != 0) chk("preg", int'(alloc_preg), e.p);
    endtask
    initial begin
        rst = 1; alloc_req = 0; free_we = 0; free_preg = 1; flush = 0;
        cyc(1, 0, 0, 1, 0);
        ph = "drain";
        for (int i = 0; i < D + 1; i++) cyc(0, 1, 0, 1, 0);
        ph = "free_empty";
        cyc(0, 0, 1, 5, 0);
        ph = "alloc_free_c1";
        cyc(0, 1, 1, 9, 0);
        ph = "alloc_free_c0";
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 1, 11, 0);
        cyc(0, 0, 0, 1, 0);
        ph = "flush";
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 1, 7, 0);
        cyc(0, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0);
        ph = "flush_free";
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 1, 12, 1);
        for (int i = 0; i < D + 1; i++) cyc(0, 1, 0, 1, 0);
        ph = "mid_reset";
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, 0);
        cyc(1, 1, 0, 1, 0);
        ph = "random";
        for (int i = 0; i < 400; i++) begin
            bit q, w, f;
            q = $urandom_range(0, 3) != 0;
            w = spec_n > 0 && $urandom_range(0, 2) == 0;
            f = $urandom_range(0, 15) == 0;
            cyc(0, q, w, $urandom_range(1, 63), f);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
